// File: rtl/cache_ctrl_nway.sv
// Controller FSM for a WAYS-way set-associative write-back cache.
// Outputs decode from the state register, so an async reset drops pmem requests immediately.
module cache_ctrl_nway #(
  parameter int WAYS        = 4,
  parameter int WRITE_ALLOC = 1,
  parameter int PERF_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [WAYS-1:0]           hit_vec,
  input  logic [WAYS-1:0]           valid_vec,
  input  logic [WAYS-1:0]           dirty_vec,
  input  logic [$clog2(WAYS)-1:0]   plru_victim,
  input  logic                      pmem_resp,
  input  logic                      perf_clr,
  output logic [$clog2(WAYS)-1:0]   way_sel,
  output logic                      load_rdata,
  output logic                      data_we,
  output logic                      data_src,
  output logic                      tag_we,
  output logic                      valid_we,
  output logic                      dirty_we,
  output logic                      dirty_in,
  output logic                      lru_update,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic                      pmem_addr_sel,
  output logic                      pmem_wsrc,
  output logic [PERF_W-1:0]         hit_cnt,
  output logic [PERF_W-1:0]         miss_cnt,
  output logic [PERF_W-1:0]         wb_cnt
);
  localparam int WW = $clog2(WAYS);
  localparam bit NO_WALLOC = (WRITE_ALLOC == 0);

  localparam logic [2:0] S_CHECK   = 3'd0;
  localparam logic [2:0] S_RESP    = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_INSTALL = 3'd4;
  localparam logic [2:0] S_WTHRU   = 3'd5;

  logic [2:0]    r_state;
  logic [WW-1:0] r_way_q;
  logic [WW-1:0] r_victim_q;
  logic          r_wr;

  logic          w_req;
  logic          w_hit;
  logic [WW-1:0] w_hit_idx;
  logic [WW-1:0] w_inv_idx;
  logic [WW-1:0] w_victim;
  logic          w_hit_ev;
  logic          w_miss_ev;
  logic          w_wb_ev;

  function automatic logic [WW-1:0] f_lowest(input logic [WAYS-1:0] v);
    f_lowest = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = WW'(i);
    end
  endfunction

  // Invalid ways are always preferred over evicting a live line.
  assign w_req     = mem_read | mem_write;
  assign w_hit     = |hit_vec;
  assign w_hit_idx = f_lowest(hit_vec);
  assign w_inv_idx = f_lowest(~valid_vec);
  assign w_victim  = (&valid_vec) ? plru_victim : w_inv_idx;

  assign w_hit_ev  = (r_state == S_CHECK) && w_req && w_hit;
  assign w_miss_ev = (r_state == S_CHECK) && w_req && !w_hit;
  assign w_wb_ev   = (r_state == S_WB) && pmem_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_CHECK;
      r_way_q    <= '0;
      r_victim_q <= '0;
      r_wr       <= 1'b0;
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_req) begin
            r_wr <= mem_write;
            if (w_hit) begin
              r_way_q <= w_hit_idx;
              r_state <= S_RESP;
            end else if (mem_write && NO_WALLOC) begin
              r_state <= S_WTHRU;
            end else begin
              r_victim_q <= w_victim;
              r_state    <= (valid_vec[w_victim] && dirty_vec[w_victim]) ? S_WB : S_FILL;
            end
          end
        end
        S_RESP:    r_state <= S_CHECK;
        S_WB:      if (pmem_resp) r_state <= S_FILL;
        S_FILL:    if (pmem_resp) r_state <= S_INSTALL;
        S_INSTALL: begin
          r_way_q <= r_victim_q;
          r_state <= S_RESP;
        end
        S_WTHRU:   if (pmem_resp) r_state <= S_CHECK;
        default:   r_state <= S_CHECK;
      endcase
    end
  end

  // Saturating counters; a clear overrides any same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (perf_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (w_hit_ev && (hit_cnt != '1))   hit_cnt  <= hit_cnt + PERF_W'(1);
      if (w_miss_ev && (miss_cnt != '1)) miss_cnt <= miss_cnt + PERF_W'(1);
      if (w_wb_ev && (wb_cnt != '1))     wb_cnt   <= wb_cnt + PERF_W'(1);
    end
  end

  always_comb begin
    way_sel       = '0;
    load_rdata    = 1'b0;
    data_we       = 1'b0;
    data_src      = 1'b0;
    tag_we        = 1'b0;
    valid_we      = 1'b0;
    dirty_we      = 1'b0;
    dirty_in      = 1'b0;
    lru_update    = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_wsrc     = 1'b0;
    case (r_state)
      S_RESP: begin
        way_sel    = r_way_q;
        lru_update = 1'b1;
        mem_resp   = 1'b1;
        load_rdata = !r_wr;
        data_we    = r_wr;
        dirty_we   = r_wr;
        dirty_in   = r_wr;
      end
      S_WB: begin
        way_sel       = r_victim_q;
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
      end
      S_FILL: begin
        way_sel   = r_victim_q;
        pmem_read = 1'b1;
      end
      S_INSTALL: begin
        way_sel  = r_victim_q;
        data_we  = 1'b1;
        data_src = 1'b1;
        tag_we   = 1'b1;
        valid_we = 1'b1;
        dirty_we = 1'b1;
      end
      S_WTHRU: begin
        pmem_write = 1'b1;
        pmem_wsrc  = 1'b1;
        mem_resp   = pmem_resp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench: u_a is a write-allocate controller with 4-bit counters, u_b is no-write-allocate.
module tb_cache_ctrl_nway;
  logic clk = 1'b0;
  logic rst;
  logic mem_read, mem_write, mem_read_b, mem_write_b;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [1:0] plru_victim;
  logic pmem_resp, perf_clr;

  logic [1:0] a_way_sel, b_way_sel;
  logic a_load_rdata, a_data_we, a_data_src, a_tag_we, a_valid_we, a_dirty_we, a_dirty_in;
  logic a_lru_update, a_mem_resp, a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_pmem_wsrc;
  logic b_load_rdata, b_data_we, b_data_src, b_tag_we, b_valid_we, b_dirty_we, b_dirty_in;
  logic b_lru_update, b_mem_resp, b_pmem_read, b_pmem_write, b_pmem_addr_sel, b_pmem_wsrc;
  logic [3:0] a_hit_cnt, a_miss_cnt, a_wb_cnt;
  logic [7:0] b_hit_cnt, b_miss_cnt, b_wb_cnt;

  int checks = 0;
  int errors = 0;
  bit sel;

  always #5 clk = ~clk;

  cache_ctrl_nway #(.WAYS(4), .WRITE_ALLOC(1), .PERF_W(4)) u_a (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_victim(plru_victim),
    .pmem_resp(pmem_resp), .perf_clr(perf_clr), .way_sel(a_way_sel), .load_rdata(a_load_rdata),
    .data_we(a_data_we), .data_src(a_data_src), .tag_we(a_tag_we), .valid_we(a_valid_we),
    .dirty_we(a_dirty_we), .dirty_in(a_dirty_in), .lru_update(a_lru_update), .mem_resp(a_mem_resp),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write), .pmem_addr_sel(a_pmem_addr_sel),
    .pmem_wsrc(a_pmem_wsrc), .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt), .wb_cnt(a_wb_cnt));

  cache_ctrl_nway #(.WAYS(4), .WRITE_ALLOC(0), .PERF_W(8)) u_b (
    .clk(clk), .rst(rst), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_victim(plru_victim),
    .pmem_resp(pmem_resp), .perf_clr(perf_clr), .way_sel(b_way_sel), .load_rdata(b_load_rdata),
    .data_we(b_data_we), .data_src(b_data_src), .tag_we(b_tag_we), .valid_we(b_valid_we),
    .dirty_we(b_dirty_we), .dirty_in(b_dirty_in), .lru_update(b_lru_update), .mem_resp(b_mem_resp),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_addr_sel(b_pmem_addr_sel),
    .pmem_wsrc(b_pmem_wsrc), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt), .wb_cnt(b_wb_cnt));

  wire       o_pr   = sel ? b_pmem_read  : a_pmem_read;
  wire       o_pw   = sel ? b_pmem_write : a_pmem_write;
  wire       o_resp = sel ? b_mem_resp   : a_mem_resp;
  wire       o_tag  = sel ? b_tag_we     : a_tag_we;
  wire       o_wsrc = sel ? b_pmem_wsrc  : a_pmem_wsrc;
  wire [1:0] o_way  = sel ? b_way_sel    : a_way_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 pmem_resp = 1'b0;
    #1;
  endtask

  // Drives one request and answers pmem after 'waits' idle cycles; lat counts CHECK as cycle 1.
  task automatic run_req(input bit b, input bit wr, input int waits, output int lat,
                         output bit saw_wb, output bit saw_tag, output bit saw_both,
                         output bit saw_wsrc, output logic [1:0] inst_way,
                         output logic [1:0] resp_way);
    int  w;
    bit  done;
    sel = b;
    if (b) begin mem_write_b = wr; mem_read_b = !wr; end
    else   begin mem_write   = wr; mem_read   = !wr; end
    lat = 1; w = 0; done = 0;
    saw_wb = 0; saw_tag = 0; saw_both = 0; saw_wsrc = 0; inst_way = 0; resp_way = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (o_pr || o_pw) begin
        if (w == waits) begin pmem_resp = 1'b1; w = 0; end
        else w++;
      end
      #1;
      if (o_pw && !o_wsrc) saw_wb = 1;
      if (o_pr && o_pw) saw_both = 1;
      if (o_wsrc) saw_wsrc = 1;
      if (o_tag) begin saw_tag = 1; inst_way = o_way; end
      if (o_resp) begin done = 1; resp_way = o_way; end
      else begin tick(); lat++; end
    end
    if (!done) lat = -1;
    mem_read = 0; mem_write = 0; mem_read_b = 0; mem_write_b = 0;
    tick();
  endtask

  initial begin
    int lat;
    bit swb, stag, sboth, swsrc;
    logic [1:0] iway, rway;
    rst = 1'b1; sel = 0;
    mem_read = 0; mem_write = 0; mem_read_b = 0; mem_write_b = 0;
    hit_vec = 0; valid_vec = 0; dirty_vec = 0; plru_victim = 0; pmem_resp = 0; perf_clr = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_way_sel", 32'(a_way_sel), 0);
    chk("rst_pmem_read", 32'(a_pmem_read), 0);
    chk("rst_mem_resp", 32'(a_mem_resp), 0);
    chk("rst_hit_cnt", 32'(a_hit_cnt), 0);
    rst = 1'b0;
    tick();

    // read hit on way 1
    mem_read = 1; hit_vec = 4'b0010; #1;
    chk("rh_no_resp_c1", 32'(a_mem_resp), 0);
    tick();
    chk("rh_resp_c2", 32'(a_mem_resp), 1);
    chk("rh_way_sel", 32'(a_way_sel), 1);
    chk("rh_load_rdata", 32'(a_load_rdata), 1);
    chk("rh_lru_update", 32'(a_lru_update), 1);
    chk("rh_hit_cnt", 32'(a_hit_cnt), 1);
    mem_read = 0; hit_vec = 0;
    tick();
    chk("rh_resp_pulse", 32'(a_mem_resp), 0);

    // dirty write miss: victim way 2 (all valid, PLRU)
    valid_vec = 4'b1111; dirty_vec = 4'b0100; plru_victim = 2; mem_write = 1;
    tick();
    chk("wm_wb_pw", 32'(a_pmem_write), 1);
    chk("wm_wb_addr_sel", 32'(a_pmem_addr_sel), 1);
    chk("wm_wb_way", 32'(a_way_sel), 2);
    chk("wm_wb_pr", 32'(a_pmem_read), 0);
    pmem_resp = 1;
    tick();
    chk("wm_fill_pr", 32'(a_pmem_read), 1);
    chk("wm_fill_pw", 32'(a_pmem_write), 0);
    chk("wm_fill_addr_sel", 32'(a_pmem_addr_sel), 0);
    chk("wm_wb_cnt", 32'(a_wb_cnt), 1);
    chk("wm_miss_cnt", 32'(a_miss_cnt), 1);
    tick();
    chk("wm_fill_hold", 32'(a_pmem_read), 1);
    pmem_resp = 1;
    tick();
    chk("wm_inst_way", 32'(a_way_sel), 2);
    chk("wm_inst_data_we", 32'(a_data_we), 1);
    chk("wm_inst_src", 32'(a_data_src), 1);
    chk("wm_inst_tag_we", 32'(a_tag_we), 1);
    chk("wm_inst_valid_we", 32'(a_valid_we), 1);
    chk("wm_inst_dirty_we", 32'(a_dirty_we), 1);
    chk("wm_inst_dirty_in", 32'(a_dirty_in), 0);
    chk("wm_inst_no_resp", 32'(a_mem_resp), 0);
    tick();
    chk("wm_resp", 32'(a_mem_resp), 1);
    chk("wm_resp_data_we", 32'(a_data_we), 1);
    chk("wm_resp_src", 32'(a_data_src), 0);
    chk("wm_resp_dirty_in", 32'(a_dirty_in), 1);
    chk("wm_resp_way", 32'(a_way_sel), 2);
    chk("wm_resp_no_load", 32'(a_load_rdata), 0);
    mem_write = 0;
    tick();

    // read miss with an invalid way (2) preferred over PLRU (0), even though all dirty
    valid_vec = 4'b1011; dirty_vec = 4'b1111; plru_victim = 0;
    run_req(0, 0, 0, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("rm_inv_lat", 32'(lat), 4);
    chk("rm_inv_no_wb", 32'(swb), 0);
    chk("rm_inv_way", 32'(iway), 2);

    // clean miss, two pmem wait cycles
    valid_vec = 4'b1111; dirty_vec = 4'b0000; plru_victim = 1;
    run_req(0, 0, 2, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("cm_wait_lat", 32'(lat), 6);
    chk("cm_wait_way", 32'(iway), 1);
    chk("cm_wait_resp_way", 32'(rway), 1);

    // dirty read miss, zero wait
    dirty_vec = 4'b1111; plru_victim = 3;
    run_req(0, 0, 0, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("dm_lat", 32'(lat), 5);
    chk("dm_wb", 32'(swb), 1);
    chk("dm_way", 32'(iway), 3);
    chk("dm_no_both", 32'(sboth), 0);
    chk("dm_miss_cnt", 32'(a_miss_cnt), 4);
    chk("dm_wb_cnt", 32'(a_wb_cnt), 2);

    // stray pmem_resp in CHECK, then multi-hit picks lowest way
    pmem_resp = 1; tick();
    chk("stray_no_pr", 32'(a_pmem_read), 0);
    hit_vec = 4'b0110;
    run_req(0, 0, 0, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("mh_lat", 32'(lat), 2);
    chk("mh_way", 32'(rway), 1);
    chk("mh_hit_cnt", 32'(a_hit_cnt), 2);

    // no-write-allocate write miss, three wait cycles
    hit_vec = 0; valid_vec = 4'b1111; dirty_vec = 4'b1111;
    run_req(1, 1, 3, lat, swb, stag, sboth, swsrc, iway, rway);
    sel = 0;
    chk("wt_lat", 32'(lat), 5);
    chk("wt_wsrc", 32'(swsrc), 1);
    chk("wt_no_tag", 32'(stag), 0);
    chk("wt_miss_cnt", 32'(b_miss_cnt), 1);
    chk("wt_wb_cnt", 32'(b_wb_cnt), 0);

    // 15 more hits: 17 total saturates the 4-bit counter
    hit_vec = 4'b0001;
    for (int n = 0; n < 15; n++) run_req(0, 0, 0, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("sat_hit_cnt", 32'(a_hit_cnt), 15);
    chk("sat_miss_cnt", 32'(a_miss_cnt), 4);

    // clear beats a same-cycle hit
    mem_read = 1; perf_clr = 1;
    tick();
    chk("clr_hit_cnt", 32'(a_hit_cnt), 0);
    chk("clr_miss_cnt", 32'(a_miss_cnt), 0);
    chk("clr_wb_cnt", 32'(a_wb_cnt), 0);
    perf_clr = 0; mem_read = 0;
    tick();

    // reset during FILL
    hit_vec = 0; dirty_vec = 0; mem_read = 1;
    tick();
    chk("rf_fill_pr", 32'(a_pmem_read), 1);
    chk("rf_miss_cnt", 32'(a_miss_cnt), 1);
    rst = 1; #1;
    chk("rf_async_pr", 32'(a_pmem_read), 0);
    chk("rf_cnt_cleared", 32'(a_miss_cnt), 0);
    mem_read = 0;
    tick();
    rst = 0;
    tick();
    chk("rf_idle_pr", 32'(a_pmem_read), 0);
    hit_vec = 4'b1000;
    run_req(0, 0, 0, lat, swb, stag, sboth, swsrc, iway, rway);
    chk("rf_hit_lat", 32'(lat), 2);
    chk("rf_hit_way", 32'(rway), 3);
    chk("rf_hit_cnt", 32'(a_hit_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
